// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two writeback requesters.
// Grant is combinational (0 cycles), rf_* registered (1 cycle); the loser of a tie waits one cycle holding its request.
module rf_write_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt1,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WR0, WR1} state_t;

    state_t            r_state;
    logic              r_last;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    // On a tie the port that did not win last time is granted.
    assign w_gnt0 = ~rst & req0 & (~req1 | r_last);
    assign w_gnt1 = ~rst & req1 & (~req0 | ~r_last);
    assign w_any  = w_gnt0 | w_gnt1;
    assign w_addr = w_gnt1 ? addr1 : addr0;
    assign w_data = w_gnt1 ? data1 : data0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_any) begin
            r_last  <= w_gnt1;
            r_waddr <= w_addr;
            r_wdata <= w_data;
            if (w_addr != '0) begin
                r_state <= w_gnt1 ? WR1 : WR0;
            end else begin
                r_state <= IDLE;
            end
        end else begin
            r_state <= IDLE;
        end
    end

    // The write enable is the registered state: any WRx state is a live write.
    assign rf_we    = (r_state != IDLE);
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;
    assign gnt0     = w_gnt0;
    assign gnt1     = w_gnt1;
    assign busy     = req0 & req1;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter with a small register-file model.
module tb_rf_write_arbiter;

    logic        clk;
    logic        rst;
    logic        req0;
    logic [4:0]  addr0;
    logic [31:0] data0;
    logic        gnt0;
    logic        req1;
    logic [4:0]  addr1;
    logic [31:0] data1;
    logic        gnt1;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;

    int n_checks;
    int n_errors;

    logic [31:0] rf_model [0:31];

    rf_write_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .addr0    (addr0),
        .data0    (data0),
        .gnt0     (gnt0),
        .req1     (req1),
        .addr1    (addr1),
        .data1    (data1),
        .gnt1     (gnt1),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_we) rf_model[rf_waddr] <= rf_wdata;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 32; i++) rf_model[i] = 32'h0;
        rst = 1'b1;
        req0 = 1'b1; addr0 = 5'd2; data0 = 32'h1;
        req1 = 1'b0; addr1 = 5'd0; data1 = 32'h0;
        #2;
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_we", rf_we, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        req0 = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // single request
        req0 = 1'b1; addr0 = 5'd5; data0 = 32'hDEADBEEF;
        #1;
        check("single_gnt0", gnt0, 1);
        check("single_gnt1", gnt1, 0);
        check("single_busy", busy, 0);
        tick();
        check("single_we", rf_we, 1);
        check("single_waddr", rf_waddr, 5);
        check("single_wdata", rf_wdata, 32'hDEADBEEF);
        req0 = 1'b0;
        #1;
        check("single_gnt0_drop", gnt0, 0);
        tick();
        check("single_we_off", rf_we, 0);
        check("single_waddr_hold", rf_waddr, 5);
        check("single_wdata_hold", rf_wdata, 32'hDEADBEEF);

        // reset pulse between edges restores last=1
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        tick();

        // first tie after reset
        req0 = 1'b1; addr0 = 5'd3; data0 = 32'h11;
        req1 = 1'b1; addr1 = 5'd4; data1 = 32'h22;
        #1;
        check("tie_gnt0", gnt0, 1);
        check("tie_gnt1", gnt1, 0);
        check("tie_busy", busy, 1);
        tick();
        check("tie_waddr0", rf_waddr, 3);
        check("tie_wdata0", rf_wdata, 32'h11);
        req0 = 1'b0;
        #1;
        check("tie_gnt1_next", gnt1, 1);
        check("tie_busy_next", busy, 0);
        tick();
        check("tie_waddr1", rf_waddr, 4);
        check("tie_wdata1", rf_wdata, 32'h22);
        check("tie_we1", rf_we, 1);
        req1 = 1'b0;
        tick();
        check("tie_we_off", rf_we, 0);

        // sustained contention: last=1 so port 0 leads
        for (int i = 0; i < 6; i++) begin
            req0 = 1'b1; addr0 = 5'(i + 1);  data0 = 32'(100 + i);
            req1 = 1'b1; addr1 = 5'(i + 10); data1 = 32'(200 + i);
            #1;
            check("rr_gnt0", gnt0, (i % 2 == 0) ? 1 : 0);
            check("rr_gnt1", gnt1, (i % 2 == 1) ? 1 : 0);
            check("rr_excl", gnt0 & gnt1, 0);
            tick();
            check("rr_waddr", rf_waddr, (i % 2 == 0) ? (i + 1) : (i + 10));
            check("rr_wdata", rf_wdata, (i % 2 == 0) ? (100 + i) : (200 + i));
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // $0 write filter
        req1 = 1'b1; addr1 = 5'd0; data1 = 32'hFFFFFFFF;
        #1;
        check("zero_gnt1", gnt1, 1);
        tick();
        check("zero_we", rf_we, 0);
        check("zero_waddr", rf_waddr, 0);
        check("zero_wdata", rf_wdata, 32'hFFFFFFFF);
        req0 = 1'b1; addr0 = 5'd2; data0 = 32'h33;
        addr1 = 5'd9; data1 = 32'h44;
        #1;
        check("zero_tie_gnt0", gnt0, 1);
        check("zero_tie_gnt1", gnt1, 0);
        tick();
        check("zero_tie_waddr", rf_waddr, 2);
        req0 = 1'b0;
        tick();
        check("zero_tie_waddr1", rf_waddr, 9);
        req1 = 1'b0;
        tick();

        // collision on register 7 with last=0
        req0 = 1'b1; addr0 = 5'd1; data0 = 32'h77;
        tick();
        req0 = 1'b1; addr0 = 5'd7; data0 = 32'hA;
        req1 = 1'b1; addr1 = 5'd7; data1 = 32'hB;
        #1;
        check("col_gnt1", gnt1, 1);
        tick();
        check("col_first_wdata", rf_wdata, 32'hB);
        check("col_first_waddr", rf_waddr, 7);
        req1 = 1'b0;
        #1;
        check("col_gnt0", gnt0, 1);
        tick();
        check("col_second_wdata", rf_wdata, 32'hA);
        req0 = 1'b0;
        tick();
        check("col_reg7", rf_model[7], 32'hA);

        // reset during a live write
        req1 = 1'b1; addr1 = 5'd8; data1 = 32'h66;
        tick();
        check("mid_we_before", rf_we, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_we_rst", rf_we, 0);
        check("mid_waddr_rst", rf_waddr, 0);
        check("mid_wdata_rst", rf_wdata, 0);
        check("mid_gnt1_rst", gnt1, 0);
        rst = 1'b0;
        #1;
        check("mid_gnt1_after", gnt1, 1);
        tick();
        check("mid_we_after", rf_we, 1);
        check("mid_waddr_after", rf_waddr, 8);
        check("mid_wdata_after", rf_wdata, 32'h66);
        req1 = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port of the CPU between two writeback requesters: port 0 (ALU/load writeback) and port 1 (multi-cycle multiply/divide unit). Each cycle it arbitrates round-robin and grants one requester with a combinational `gnt`. It then captures the winner's 5-bit destination and 32-bit data through 2:1 selectors into a registered write stage that drives the register file. Writes to `$0` are consumed but never reach the register file.

## Interface
Parameters:
- `ADDR_W`, 5: register address width.
- `DATA_W`, 32: write data width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0`  in  1  port 0 write request; held with its fields until `gnt0`.
- `addr0`  in  ADDR_W  port 0 destination register.
- `data0`  in  DATA_W  port 0 write data.
- `gnt0`  out  1  combinational grant to port 0; the request is consumed at the next rising edge.
- `req1`, `addr1`, `data1`, `gnt1`: same as port 0, for port 1.
- `rf_we`  out  1  registered register-file write enable.
- `rf_waddr`  out  ADDR_W  registered write address.
- `rf_wdata`  out  DATA_W  registered write data.
- `busy`  out  1  combinational; high when both `req0` and `req1` are high, meaning one of them must wait.

## Operation
- State: FSM `state` ∈ {IDLE, WR0, WR1}, plus the 1-bit pointer `last` holding the most recent winner.
- Grant logic (combinational, gated to 0 while `rst` is high):
  - Only `req0` high: `gnt0` = 1.
  - Only `req1` high: `gnt1` = 1.
  - Both high: grant the port ≠ `last`.
  - Neither high: no grant.
  - `gnt0` and `gnt1` are never high together.
- Selectors: the winner index drives 2:1 selectors on address (5-bit) and data (32-bit). If there is no winner, the selector output is don't-care and is not captured.
- Rising edge with a grant to port `p`:
  - `last` ← `p`; `rf_waddr` ← `addr_p`; `rf_wdata` ← `data_p`.
  - If `addr_p` ≠ 0: `rf_we` ← 1 and `state` ← WR`p`.
  - If `addr_p` == 0: `rf_we` ← 0 and `state` ← IDLE. The request is still consumed and still updates `last`.
- Rising edge with no grant:
  - `state` ← IDLE; `rf_we` ← 0.
  - `rf_waddr` and `rf_wdata` hold their values.
  - `last` unchanged.
- Transitions (all state pairs are legal):
  - IDLE → WR0 or WR1 on a nonzero-address grant.
  - WR`x` → WR`y` on back-to-back grants.
  - Any state → IDLE on no grant or a `$0` grant.
- Requester rule: after seeing `gnt` high at an edge, the requester either drops `req` or presents its next write in the following cycle. Back-to-back acceptance from one port is allowed when the other port is idle.
- Same address from both ports in one cycle: the round-robin winner writes first and the loser writes one cycle later. The last write wins in the register file; the arbiter performs no merging.
- Fields of a non-granted request are ignored. Changing them while waiting is a requester protocol violation; the arbiter captures whatever is present on the granting edge.

## Timing
- Reset values (applied asynchronously while `rst` = 1):
  - `state` = IDLE.
  - `last` = 1, so port 0 wins the first tie.
  - `rf_we` = 0, `rf_waddr` = 0, `rf_wdata` = 0.
  - `gnt0` = `gnt1` = 0.
- Grant latency: 0 cycles. The grant is in the same cycle as `req`.
- Write latency: `rf_*` is valid in the cycle after the granting edge, and the register file commits at the following edge.
- Throughput: one write per cycle. Under continuous contention the ports alternate strictly 0,1,0,1…, so the maximum wait for either port is 1 cycle.
- Reset asserted mid-operation:
  - A pending `rf_we` is cleared immediately and that write is lost.
  - Grants go low immediately.
  - Requesters keep holding `req` and are serviced after `rst` deasserts, with port 0 preferred.
- Reset deassertion: the first edge after `rst` falls performs a normal arbitration.

## Test plan
- Reset then single request: `req0`=1, `addr0`=5, `data0`=0xDEADBEEF → `gnt0`=1 in the same cycle. Next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF, then `rf_we`=0 once `req0` drops.
- First tie after reset: both requests held (`addr0`=3/`data0`=0x11, `addr1`=4/`data1`=0x22) → port 0 granted first and port 1 on the next cycle. `rf_waddr` sequence is 3, 4 and `busy`=1 in the first cycle only.
- Sustained contention: both ports present a new write every cycle for 6 cycles → grants alternate 0,1,0,1,0,1, and `gnt0`&`gnt1` is never 1.
- `$0` filter: `req1`=1, `addr1`=0, `data1`=0xFFFFFFFF → `gnt1`=1, `rf_we` stays 0, state stays IDLE, and a following tie grants port 0 (because `last`=1).
- Same-address collision: both ports target register 7 (`data0`=0xA, `data1`=0xB) with `last`=0 → port 1 writes 0xB first, then port 0 writes 0xA. Register 7 ends at 0xA.
- Reset mid-write: assert `rst` in the cycle where `rf_we`=1 → `rf_we`, `rf_waddr` and `rf_wdata` are 0 without waiting for a clock edge. After deassertion, a held `req1` is granted on the next edge.
